ct_ifu_spsram_arb_2048x59: RTL and testbench

- Owns the single port of one 2048x59 IFU SPSRAM macro: active-low CEN, active-low GWEN and an active-low per-bit WEN mask.
- Shares the port between three clients:
  - an internal invalidate sequencer that walks all entries writing INV_DATA;
  - a refill write requester;
  - a fetch read requester.
- Registers the macro inputs and returns read data with a fixed latency.
- Sits between IFU fetch/refill control and the SRAM macro wrapper.

---
 rtl/ct_ifu_spsram_arb_pkg.sv | 18 +
 rtl/ct_ifu_spsram_inv_seq.sv | 57 +++++
 rtl/ct_ifu_spsram_arb_2048x59.sv | 101 ++++++++++
 tb/tb_ct_ifu_spsram_arb_2048x59.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ct_ifu_spsram_arb_pkg.sv
// Shared types and constants for the IFU SPSRAM port arbiter.
package ct_ifu_spsram_arb_pkg;

    localparam int ARB_ADDR_WIDTH = 11;
    localparam int ARB_DATA_WIDTH = 59;
    localparam int SRAM_DEPTH     = 1 << ARB_ADDR_WIDTH;

    // Active-low per-bit write enables: WEN_NONE masks every bit, WEN_ALL writes every bit.
    localparam logic [ARB_DATA_WIDTH-1:0] WEN_NONE = {ARB_DATA_WIDTH{1'b1}};
    localparam logic [ARB_DATA_WIDTH-1:0] WEN_ALL  = {ARB_DATA_WIDTH{1'b0}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INV  = 2'd1,
        DONE = 2'd2
    } inv_state_e;

endpackage

// File: rtl/ct_ifu_spsram_inv_seq.sv
// Invalidate sequencer: walks every SRAM entry once per request (or after reset),
// then pulses inv_done for one cycle.
module ct_ifu_spsram_inv_seq
    import ct_ifu_spsram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH    = ARB_ADDR_WIDTH,
    parameter bit INIT_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inv_req,
    output logic                  inv_busy,
    output logic                  inv_done,
    output logic [ADDR_WIDTH-1:0] inv_addr,
    output inv_state_e            state
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

    logic init_pend;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            inv_addr  <= '0;
            inv_done  <= 1'b0;
            init_pend <= INIT_ON_RESET;
        end else begin
            inv_done  <= 1'b0;
            init_pend <= 1'b0;
            case (state)
                IDLE: begin
                    if (init_pend || inv_req) begin
                        state <= INV;
                    end
                end
                INV: begin
                    if (inv_addr == LAST_ADDR) begin
                        state    <= DONE;
                        inv_done <= 1'b1;
                    end else begin
                        inv_addr <= inv_addr + 1'b1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    inv_addr <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The post-reset start is reported as busy before the FSM leaves IDLE so clients hold off.
    assign inv_busy = (state != IDLE) | (init_pend & ~rst);

endmodule

// File: rtl/ct_ifu_spsram_arb_2048x59.sv
// Single-port arbiter for the 2048x59 IFU SPSRAM: invalidate > refill write > fetch read,
// registered macro inputs, read data returned two cycles after the grant.
module ct_ifu_spsram_arb_2048x59
    import ct_ifu_spsram_arb_pkg::*;
#(
    parameter int                    ADDR_WIDTH    = ARB_ADDR_WIDTH,
    parameter int                    DATA_WIDTH    = ARB_DATA_WIDTH,
    parameter bit                    INIT_ON_RESET = 1'b1,
    parameter logic [DATA_WIDTH-1:0] INV_DATA      = '0
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst,
    input  logic                  inv_req,
    output logic                  inv_busy,
    output logic                  inv_done,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [DATA_WIDTH-1:0] wr_bmask,
    output logic                  wr_gnt,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_gnt,
    output logic                  rd_vld,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q
);

    localparam logic [DATA_WIDTH-1:0] WEN_OFF = {DATA_WIDTH{1'b1}};
    localparam logic [DATA_WIDTH-1:0] WEN_ON  = {DATA_WIDTH{1'b0}};

    logic                  seq_wr;
    logic [ADDR_WIDTH-1:0] seq_addr;
    inv_state_e            seq_state;
    logic [1:0]            rd_pipe;

    ct_ifu_spsram_inv_seq #(
        .ADDR_WIDTH    (ADDR_WIDTH),
        .INIT_ON_RESET (INIT_ON_RESET)
    ) u_inv_seq (
        .clk      (forever_cpuclk),
        .rst      (cpurst),
        .inv_req  (inv_req),
        .inv_busy (inv_busy),
        .inv_done (inv_done),
        .inv_addr (seq_addr),
        .state    (seq_state)
    );

    assign seq_wr = (seq_state == INV);

    // Request/grant: a client keeps *_req high until it sees *_gnt in the same cycle;
    // the access is taken at that clock edge and nothing is queued for a blocked client.
    assign wr_gnt = wr_req & ~inv_busy;
    assign rd_gnt = rd_req & ~wr_req & ~inv_busy;

    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            sram_cen  <= 1'b1;
            sram_gwen <= 1'b1;
            sram_wen  <= WEN_OFF;
            sram_a    <= '0;
            sram_d    <= '0;
            rd_pipe   <= '0;
        end else begin
            rd_pipe <= {rd_pipe[0], rd_gnt};
            if (seq_wr) begin
                sram_cen  <= 1'b0;
                sram_gwen <= 1'b0;
                sram_wen  <= WEN_ON;
                sram_a    <= seq_addr;
                sram_d    <= INV_DATA;
            end else if (wr_gnt) begin
                sram_cen  <= 1'b0;
                sram_gwen <= 1'b0;
                sram_wen  <= ~wr_bmask;
                sram_a    <= wr_addr;
                sram_d    <= wr_data;
            end else if (rd_gnt) begin
                sram_cen  <= 1'b0;
                sram_gwen <= 1'b1;
                sram_wen  <= WEN_OFF;
                sram_a    <= rd_addr;
            end else begin
                // Idle port: address and data lines hold to avoid needless toggling.
                sram_cen  <= 1'b1;
                sram_gwen <= 1'b1;
                sram_wen  <= WEN_OFF;
            end
        end
    end

    assign rd_vld  = rd_pipe[1];
    assign rd_data = sram_q;

endmodule

// File: tb/tb_ct_ifu_spsram_arb_2048x59.sv
// Bench for the IFU SPSRAM arbiter: macro model, cycle-level behavioural reference and directed scenarios.
module tb_ct_ifu_spsram_arb_2048x59;
    import ct_ifu_spsram_arb_pkg::*;

    localparam int AW = 11;
    localparam int DW = 59;
    localparam logic [DW-1:0] ONES = {DW{1'b1}};

    logic          clk;
    logic          cpurst;
    logic          inv_req;
    logic          inv_busy;
    logic          inv_done;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] wr_bmask;
    logic          wr_gnt;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_gnt;
    logic          rd_vld;
    logic [DW-1:0] rd_data;
    logic          sram_cen;
    logic          sram_gwen;
    logic [DW-1:0] sram_wen;
    logic [AW-1:0] sram_a;
    logic [DW-1:0] sram_d;
    logic [DW-1:0] sram_q;

    int n_cmp = 0;
    int n_err = 0;

    ct_ifu_spsram_arb_2048x59 dut (
        .forever_cpuclk (clk),
        .cpurst         (cpurst),
        .inv_req        (inv_req),
        .inv_busy       (inv_busy),
        .inv_done       (inv_done),
        .wr_req         (wr_req),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .wr_bmask       (wr_bmask),
        .wr_gnt         (wr_gnt),
        .rd_req         (rd_req),
        .rd_addr        (rd_addr),
        .rd_gnt         (rd_gnt),
        .rd_vld         (rd_vld),
        .rd_data        (rd_data),
        .sram_cen       (sram_cen),
        .sram_gwen      (sram_gwen),
        .sram_wen       (sram_wen),
        .sram_a         (sram_a),
        .sram_d         (sram_d),
        .sram_q         (sram_q)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- SRAM macro model ----------------
    logic [DW-1:0] mem [0:SRAM_DEPTH-1];

    always @(posedge clk) begin
        if (!sram_cen) begin
            if (!sram_gwen) mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
            else            sram_q <= mem[sram_a];
        end
    end

    // ---------------- check helper ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference + scoreboard ----------------
    // m_inv_pos: -1 when no invalidate; 0..DEPTH-1 = entry written this cycle; DEPTH = done cycle.
    logic [DW-1:0] ref_mem [0:SRAM_DEPTH-1];
    logic [DW-1:0] exp_q[$];
    int            due_q[$];
    int            m_inv_pos = -1;
    int            cyc = 0;
    logic          e_cen, e_gwen;
    logic [DW-1:0] e_wen, e_d;
    logic [AW-1:0] e_a;
    int busy_run = 0, last_busy_run = 0, done_cnt = 0, gnt_busy_cnt = 0, inv_wr_cnt = 0;

    always @(negedge clk) begin : compare
        logic eb, e_wg, e_rg;
        if (cpurst) begin
            chk("rst_cen", sram_cen, 1);
            chk("rst_gwen", sram_gwen, 1);
            chk("rst_wen", sram_wen, ONES);
            chk("rst_a", sram_a, 0);
            chk("rst_d", sram_d, 0);
            chk("rst_rd_vld", rd_vld, 0);
            chk("rst_inv_done", inv_done, 0);
            chk("rst_inv_busy", inv_busy, 0);
            // Release happens just before an edge, which consumes the pending auto-start.
            m_inv_pos = 0;
            e_cen = 1'b1; e_gwen = 1'b1; e_wen = ONES; e_a = '0; e_d = '0;
            exp_q.delete();
            due_q.delete();
            busy_run = 0; done_cnt = 0; gnt_busy_cnt = 0; inv_wr_cnt = 0;
        end else begin
            eb   = (m_inv_pos >= 0);
            e_wg = !eb && wr_req;
            e_rg = !eb && rd_req && !wr_req;
            chk("inv_busy", inv_busy, eb);
            chk("inv_done", inv_done, m_inv_pos == SRAM_DEPTH);
            chk("sram_cen", sram_cen, e_cen);
            chk("sram_gwen", sram_gwen, e_gwen);
            chk("sram_wen", sram_wen, e_wen);
            chk("sram_a", sram_a, e_a);
            chk("sram_d", sram_d, e_d);
            chk("wr_gnt", wr_gnt, e_wg);
            chk("rd_gnt", rd_gnt, e_rg);
            if (due_q.size() > 0 && due_q[0] == cyc) begin
                chk("rd_vld", rd_vld, 1);
                chk("rd_data", rd_data, exp_q.pop_front());
                void'(due_q.pop_front());
            end else begin
                chk("rd_vld_idle", rd_vld, 0);
            end

            if (inv_busy) busy_run++;
            else if (busy_run != 0) begin last_busy_run = busy_run; busy_run = 0; end
            if (inv_done) done_cnt++;
            if (inv_busy && (wr_gnt || rd_gnt)) gnt_busy_cnt++;
            if (!sram_cen && !sram_gwen && sram_wen == '0 && sram_d == '0 && sram_a == 11'(inv_wr_cnt))
                inv_wr_cnt++;

            // What this cycle's winner puts on the macro pins next cycle.
            if (m_inv_pos >= 0 && m_inv_pos < SRAM_DEPTH) begin
                e_cen = 1'b0; e_gwen = 1'b0; e_wen = '0; e_a = 11'(m_inv_pos); e_d = '0;
                ref_mem[m_inv_pos] = '0;
            end else if (e_wg) begin
                e_cen = 1'b0; e_gwen = 1'b0; e_wen = ~wr_bmask; e_a = wr_addr; e_d = wr_data;
                ref_mem[wr_addr] = (ref_mem[wr_addr] & ~wr_bmask) | (wr_data & wr_bmask);
            end else if (e_rg) begin
                e_cen = 1'b0; e_gwen = 1'b1; e_wen = ONES; e_a = rd_addr;
                exp_q.push_back(ref_mem[rd_addr]);
                due_q.push_back(cyc + 2);
            end else begin
                e_cen = 1'b1; e_gwen = 1'b1; e_wen = ONES;
            end

            if (m_inv_pos >= SRAM_DEPTH) m_inv_pos = -1;
            else if (m_inv_pos >= 0)     m_inv_pos++;
            else if (inv_req)            m_inv_pos = 0;
        end
        cyc++;
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        cpurst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #3 cpurst = 1'b0;
        #1 chk("init_pend_busy", inv_busy, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (inv_busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("wait_idle_timeout", inv_busy, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic write_once(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] m,
                              input string name);
        wr_req = 1'b1; wr_addr = a; wr_data = d; wr_bmask = m;
        @(negedge clk);
        chk(name, wr_gnt, 1);
        @(posedge clk);
        #1 wr_req = 1'b0;
    endtask

    task automatic read_lit(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string name);
        rd_req = 1'b1; rd_addr = a;
        @(negedge clk);
        chk({name, "_gnt"}, rd_gnt, 1);
        @(posedge clk);
        #1 rd_req = 1'b0;
        @(negedge clk);
        chk({name, "_vld_t1"}, rd_vld, 0);
        @(negedge clk);
        chk({name, "_vld_t2"}, rd_vld, 1);
        chk({name, "_data"}, rd_data, exp);
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int rg_cnt, d0, n;
        logic [63:0] r64;
        inv_req = 0; wr_req = 0; rd_req = 0;
        wr_addr = '0; wr_data = '0; wr_bmask = '0; rd_addr = '0;

        // Power-on invalidate with both clients requesting throughout.
        do_reset();
        wr_req = 1'b1; wr_addr = 11'h7; wr_data = 59'h123; wr_bmask = ONES;
        rd_req = 1'b1; rd_addr = 11'h9;
        wait_idle();
        wr_req = 1'b0; rd_req = 1'b0;
        @(posedge clk); #1;
        chk("init_busy_cycles", last_busy_run, 2049);
        chk("init_done_pulses", done_cnt, 1);
        chk("init_gnt_in_busy", gnt_busy_cnt, 0);
        chk("init_inv_writes", inv_wr_cnt, 2048);

        // Write then read at 0x2A5.
        write_once(11'h2A5, 59'h5A5A5A5A5A5A5A5, ONES, "wr_gnt_2a5");
        read_lit(11'h2A5, 59'h5A5A5A5A5A5A5A5, "rd_2a5");

        // Partial byte-mask write.
        write_once(11'h010, 59'h7FF_FFFF_FFFF_FFFF, ONES, "wr_gnt_pre");
        write_once(11'h010, 59'h0, 59'h0FF, "wr_gnt_mask");
        read_lit(11'h010, 59'h7FF_FFFF_FFFF_FF00, "rd_mask");

        // Simultaneous write and read requests.
        wr_req = 1'b1; wr_addr = 11'h20; wr_data = 59'h1; wr_bmask = ONES;
        rd_req = 1'b1; rd_addr = 11'h2A5;
        @(negedge clk);
        chk("sim_wr_gnt", wr_gnt, 1);
        chk("sim_rd_blocked", rd_gnt, 0);
        @(posedge clk); #1 wr_req = 1'b0;
        @(negedge clk);
        chk("sim_rd_gnt_next", rd_gnt, 1);
        @(posedge clk); #1 rd_req = 1'b0;
        repeat (3) @(posedge clk); #1;

        // inv_req while reading every cycle, with a second inv_req mid-sequence.
        rd_req = 1'b1; rd_addr = 11'h2A5; inv_req = 1'b1;
        @(negedge clk);
        chk("inv_cycle_rd_gnt", rd_gnt, 1);
        d0 = done_cnt;
        rg_cnt = 0;
        for (int i = 0; i < 2049; i++) begin
            @(posedge clk); #1 inv_req = (i == 500);
            @(negedge clk);
            if (rd_gnt) rg_cnt++;
        end
        @(posedge clk); #1 inv_req = 1'b0;
        @(negedge clk);
        chk("inv_rd_gnt_after", rd_gnt, 1);
        @(posedge clk); #1 rd_req = 1'b0;
        chk("inv_rd_gnt_blocked", rg_cnt, 0);
        chk("inv_busy_cycles", last_busy_run, 2049);
        chk("inv_done_once", done_cnt - d0, 1);
        repeat (3) @(posedge clk); #1;
        read_lit(11'h2A5, 59'h0, "rd_after_inv");

        // Reset while counter is 1000.
        inv_req = 1'b1;
        @(posedge clk); #1 inv_req = 1'b0;
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (m_inv_pos != 1001 && n < 3000);
        chk("reach_cnt1000", m_inv_pos, 1001);
        do_reset();
        @(negedge clk);
        @(negedge clk);
        chk("restart_cen", sram_cen, 0);
        chk("restart_a0", sram_a, 0);
        wait_idle();

        // Reset with a read in flight: its rd_vld must never appear.
        rd_req = 1'b1; rd_addr = 11'h3;
        @(negedge clk);
        chk("squash_rd_gnt", rd_gnt, 1);
        @(posedge clk); #1 rd_req = 1'b0;
        do_reset();
        wait_idle();

        // Random traffic on a small address window, one invalidate in the middle.
        for (int i = 0; i < 700; i++) begin
            wr_req  = ($urandom_range(0, 2) == 0);
            rd_req  = ($urandom_range(0, 1) == 0);
            inv_req = (i == 300);
            wr_addr = 11'($urandom_range(0, 15));
            rd_addr = 11'($urandom_range(0, 15));
            r64 = {$urandom(), $urandom()};
            wr_data = r64[DW-1:0];
            r64 = {$urandom(), $urandom()};
            wr_bmask = ($urandom_range(0, 1) == 0) ? ONES : r64[DW-1:0];
            @(posedge clk); #1;
        end
        wr_req = 1'b0; rd_req = 1'b0; inv_req = 1'b0;
        repeat (4) @(posedge clk); #1;
        chk("exp_q_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got running expected finished");
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "timeout");
    end

endmodule
